// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack port between the fetch unit (master) and memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem handshake, fetch buffer feeding IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN: flags misaligned redirect targets instead of fetching them.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic                  o_valid,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus_4,
  output logic [31:0]           o_Instruction
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                  o_misalign
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state_reg;
  logic        imem_req_reg;
  logic [31:0] imem_addr_reg;
  logic [31:0] fetch_pc_reg;
  logic        mis_reg;

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] occ_reg;
  logic [31:0]   pc_mem  [BUF_DEPTH];
  logic [31:0]   ins_mem [BUF_DEPTH];

  logic                 buf_valid;
  logic                 pop;
  logic                 ack_fire;
  logic                 push;
  logic                 space_ok;
  logic                 room_after;
  logic                 rd_mis;
  logic                 mis_show;
  logic [31:0]          rd_target;
  logic [CW-1:0]        occ_less_pop;
  logic [CW-1:0]        occ_after;
  logic [BUF_DEPTH-1:0] wr_en;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign rd_target  = redirect_pc;
  assign rd_mis     = |redirect_pc[1:0];
  assign mis_show   = mis_reg & ~buf_valid;
  assign o_misalign = mis_show;
`else
  assign rd_target  = redirect_pc & 32'hFFFF_FFFC;
  assign rd_mis     = 1'b0;
  assign mis_show   = 1'b0;
`endif

  assign buf_valid    = (occ_reg != '0);
  assign pop          = buf_valid & ~if_stall & ~redirect_valid;
  assign ack_fire     = imem_req_reg & imem.imem_ack;
  // Data acked in the same cycle as a redirect belongs to the old stream.
  assign push         = (state_reg == REQ) & ack_fire & ~redirect_valid;
  assign occ_less_pop = occ_reg - CW'(pop);
  assign occ_after    = occ_less_pop + CW'(push);
  assign space_ok     = (occ_less_pop < DEPTH_C);
  assign room_after   = (occ_after < DEPTH_C);

  assign imem.imem_req  = imem_req_reg;
  assign imem.imem_addr = imem_addr_reg;

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      imem_req_reg  <= 1'b0;
      imem_addr_reg <= 32'd0;
      fetch_pc_reg  <= RESET_PC;
      mis_reg       <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_reg <= rd_target;
        mis_reg      <= rd_mis;
      end else if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end

      case (state_reg)
        IDLE: begin
          if (!redirect_valid && !mis_reg && space_ok) begin
            state_reg     <= REQ;
            imem_req_reg  <= 1'b1;
            imem_addr_reg <= fetch_pc_reg;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            // An unacked request must still complete at its old address.
            if (ack_fire) begin
              state_reg    <= IDLE;
              imem_req_reg <= 1'b0;
            end else begin
              state_reg <= DROP;
            end
          end else if (ack_fire) begin
            if (room_after) begin
              imem_addr_reg <= fetch_pc_reg + 32'd4;
            end else begin
              state_reg    <= IDLE;
              imem_req_reg <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ack_fire) begin
            if (redirect_valid ? rd_mis : mis_reg) begin
              state_reg    <= IDLE;
              imem_req_reg <= 1'b0;
            end else begin
              state_reg     <= REQ;
              imem_addr_reg <= redirect_valid ? rd_target : fetch_pc_reg;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      occ_reg <= occ_after;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (!rst) begin
        pc_mem[i]  <= 32'd0;
        ins_mem[i] <= 32'd0;
      end else if (wr_en[i]) begin
        pc_mem[i]  <= fetch_pc_reg;
        ins_mem[i] <= imem.imem_rdata;
      end
    end
  end

  always_comb begin
    logic [31:0] head_pc;
    head_pc       = 32'd0;
    o_Instruction = 32'd0;
    if (buf_valid) begin
      head_pc       = pc_mem[rd_ptr_reg];
      o_Instruction = ins_mem[rd_ptr_reg];
    end else if (mis_show) begin
      head_pc = fetch_pc_reg;
    end
    o_valid     = buf_valid | mis_show;
    o_pc        = head_pc;
    o_pc_plus_4 = (buf_valid | mis_show) ? head_pc + 32'd4 : 32'd0;
  end

endmodule
